dma_bd_ram_arbiter: RTL and testbench
=====================================

// Module: dma_bd_ram_arbiter
// PURPOSE
//  Shares the single-write/single-read buffer-descriptor RAM wrapper between NUM_REQ requesters.
//  Typical requesters: descriptor fetch engine, AXI4-Lite config path and status write-back.
//  Independent round-robin arbitration for the write port and the read port; one write and one read can issue per cycle.
//  Returns read data to the originating requester at a fixed latency and routes ECC error flags.
//  Sits between the DMA channel logic and the BD RAM wrapper.
// PARAMETERS
//  NUM_REQ     3  number of requesters (2..8)
//  ADDR_W      2  BD RAM address width; matches NUM_INT_BDS_WIDTH of the RAM wrapper
//  RD_LATENCY  2  cycles from ram_rdEn to valid ram_rdData (RAM wrapper pipelined)
//  ID_W        $clog2(NUM_REQ); local parameter, not overridable
// PORTS
//  clock         in   1               single clock, rising edge
//  reset         in   1               synchronous, active-high
//  req_valid     in   NUM_REQ         per-requester access request
//  req_we        in   NUM_REQ         1 = write, 0 = read
//  req_addr      in   NUM_REQ*ADDR_W  packed addresses; requester i uses slice i
//  req_wdata     in   NUM_REQ*32      packed write data
//  req_ready     out  NUM_REQ         grant; request is consumed when valid&ready
//  rsp_valid     out  NUM_REQ         one-hot; read data returned to this requester
//  rsp_data      out  32              read data, qualified by rsp_valid
//  err_valid     out  NUM_REQ         one-hot; ECC status for the earlier read
//  err_sb        out  1               single-bit corrected, qualified by err_valid
//  err_db        out  1               double-bit detected, qualified by err_valid
//  ram_wrEn      out  1               to RAM wrapper wrEn
//  ram_wrAddr    out  ADDR_W          to RAM wrapper wrAddr
//  ram_wrData    out  32              to RAM wrapper wrData
//  ram_rdEn      out  1               to RAM wrapper rdEn
//  ram_rdAddr    out  ADDR_W          to RAM wrapper rdAddr
//  ram_rdData    in   32              from RAM wrapper rdData
//  ram_sb        in   1               from RAM wrapper error_flag_sb_bd
//  ram_db        in   1               from RAM wrapper error_flag_db_bd
// BEHAVIOUR
//  - Reset values: all outputs 0; both round-robin pointers 0; read-tag pipeline cleared.
//    A request in flight when reset asserts is dropped. No response is issued for it.
//  - Request hold rule: a requester holds valid, we, addr and wdata stable until ready.
//  - Grant: combinational. req_ready[i] = 1 only for the single winner of its class (write or read).
//  - Priority: round-robin within each class, starting at pointer, ascending index with wrap NUM_REQ-1 -> 0.
//  - Pointer update: after a grant, that class's pointer becomes winner+1 mod NUM_REQ. No grant, no pointer change.
//  - RAM drive: ram_wrEn/ram_rdEn = a grant exists in that class. The RAM address and data outputs are muxed combinationally from the winner.
//  - Read-after-write hazard: write winner and read winner target the same address in the same cycle.
//    -> the write is granted; the read is not granted that cycle and the read pointer is held.
//    -> the read is granted the next cycle, so it always returns the new data.
//  - Read response: the winner id enters an RD_LATENCY-deep tag shift register.
//    rsp_valid[id] = 1 exactly RD_LATENCY cycles after the grant; rsp_data = ram_rdData (pass-through).
//    Throughput is one read per cycle; responses come back in issue order with no backpressure.
//  - ECC routing: the wrapper registers its flags one cycle later.
//    err_valid[id] is asserted RD_LATENCY+1 cycles after the grant, with err_sb = ram_sb and err_db = ram_db.
//  - Simultaneous requests: a requester with valid on both classes in different cycles is legal.
//    Each requester owns only one outstanding request per cycle (one req_we bit).
// CONFIGURATION
//  Macro: DMA_BD_ARB_ECC_LOG_EN
//  Defined:
//   - Adds sticky registers: first_err_addr[ADDR_W], first_err_db, sb_count[15:0] (saturates at 16'hFFFF).
//     These registers are read-only outputs.
//   - first_err_* are captured on the first err_valid with sb|db; held until reset.
//   - sb_count increments on each err_valid with err_sb.
//   - The read address travels in the tag pipeline alongside the id, for first_err_addr.
//  Undefined:
//   - The log registers and ports are absent; the address is not carried in the pipeline.
// STRUCTURE
//  - Shared package (dma_bd_pkg): BD_DATA_W = 32; RD_LATENCY default; requester index constants (REQ_FETCH, REQ_CFG, REQ_WB).
//  - Sub-module: dma_rr_arbiter (NUM_REQ request vector, pointer, one-hot grant).
//    Instantiated twice, once per class; owns its pointer register.
// TESTING
//  1. Reset: assert reset 2 cycles during traffic -> all outputs 0, pointers 0, no rsp_valid afterwards.
//  2. Write-then-read: req0 writes 32'hDEAD_BEEF to addr 1, then req1 reads addr 1
//     -> rsp_valid = 3'b010 two cycles after the read grant, rsp_data = 32'hDEAD_BEEF.
//  3. Round-robin: all 3 requesters continuously request reads
//     -> read grants 0,1,2,0,1,2; ram_rdEn high every cycle; responses in the same order.
//  4. RAW hazard: same cycle, req0 writes 32'h1234_5678 to addr 2 and req1 reads addr 2
//     -> read granted one cycle later; it returns 32'h1234_5678.
//  5. ECC: force ram_sb = 1 for one read by req2
//     -> err_valid = 3'b100 and err_sb = 1 three cycles after the grant.
//     With DMA_BD_ARB_ECC_LOG_EN defined: sb_count = 1 and first_err_addr = that address.
//  6. Concurrent classes: req0 writes addr 0 while req2 reads addr 3 in the same cycle
//     -> both granted that cycle; ram_wrEn = ram_rdEn = 1.

Source files
------------

// File: rtl/dma_bd_pkg.sv
// Shared definitions for the buffer-descriptor RAM arbiter: data width,
// default read latency, requester index map and the round-robin wrap helper.
package dma_bd_pkg;

  localparam int BD_DATA_W          = 32;
  localparam int RD_LATENCY_DEFAULT = 2;

  localparam int REQ_FETCH = 0;
  localparam int REQ_CFG   = 1;
  localparam int REQ_WB    = 2;

  // idx is at most 2*n-2 here, so a single subtraction wraps it into 0..n-1.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/dma_rr_arbiter.sv
// Round-robin arbiter over N request lines. It reports the winner even while
// hold is high so that the caller can run address checks against it.
module dma_rr_arbiter
  import dma_bd_pkg::*;
#(
  parameter int N    = 3,
  parameter int ID_W = $clog2(N)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic            hold,
  output logic            win_valid,
  output logic [ID_W-1:0] win_id,
  output logic [N-1:0]    grant
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] cand_id;
  int              cand;

  // Scan upward from ptr and wrap; the first active line wins.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    cand      = 0;
    cand_id   = '0;
    for (int k = 0; k < N; k++) begin
      cand    = rr_wrap(int'(ptr) + k, N);
      cand_id = ID_W'(cand);
      if (!win_valid && req[cand_id]) begin
        win_valid = 1'b1;
        win_id    = cand_id;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (win_valid && !hold) grant[win_id] = 1'b1;
  end

  // The pointer moves only when a grant is actually issued.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (win_valid && !hold) begin
      ptr <= ID_W'(rr_wrap(int'(win_id) + 1, N));
    end
  end

endmodule

// File: rtl/dma_bd_ram_arbiter.sv
// Shares the single-write/single-read BD RAM wrapper between NUM_REQ requesters,
// with per-class round-robin arbitration, read-response routing and ECC flag routing.
// Optional ECC error log enabled by defining DMA_BD_ARB_ECC_LOG_EN.
module dma_bd_ram_arbiter
  import dma_bd_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_W     = 2,
  parameter int RD_LATENCY = RD_LATENCY_DEFAULT
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]      req_addr,
  input  logic [NUM_REQ*BD_DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [BD_DATA_W-1:0]           rsp_data,
  output logic [NUM_REQ-1:0]             err_valid,
  output logic                           err_sb,
  output logic                           err_db,
  output logic                           ram_wrEn,
  output logic [ADDR_W-1:0]              ram_wrAddr,
  output logic [BD_DATA_W-1:0]           ram_wrData,
  output logic                           ram_rdEn,
  output logic [ADDR_W-1:0]              ram_rdAddr,
  input  logic [BD_DATA_W-1:0]           ram_rdData,
  input  logic                           ram_sb,
  input  logic                           ram_db
`ifdef DMA_BD_ARB_ECC_LOG_EN
  ,
  output logic [ADDR_W-1:0]              first_err_addr,
  output logic                           first_err_db,
  output logic [15:0]                    sb_count
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int LAST = RD_LATENCY - 1;

  // Handshake: requester i raises req_valid[i] with req_we/addr/wdata and holds
  // them stable; the access is consumed in the cycle req_ready[i] is high.
  // Read responses carry no ready: rsp_valid and err_valid cannot be stalled.
  logic [NUM_REQ-1:0] wr_req, rd_req;
  logic [NUM_REQ-1:0] wr_grant, rd_grant;
  logic               wr_win_valid, rd_win_valid;
  logic [ID_W-1:0]    wr_win_id, rd_win_id;
  logic [ADDR_W-1:0]  wr_win_addr, rd_win_addr;
  logic [BD_DATA_W-1:0] wr_win_data;
  logic               raw_hazard;
  logic               rd_hold;

  assign wr_req = req_valid & req_we;
  assign rd_req = req_valid & ~req_we;

  dma_rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_wr_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (wr_req),
    .hold      (reset),
    .win_valid (wr_win_valid),
    .win_id    (wr_win_id),
    .grant     (wr_grant)
  );

  dma_rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_rd_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (rd_req),
    .hold      (rd_hold),
    .win_valid (rd_win_valid),
    .win_id    (rd_win_id),
    .grant     (rd_grant)
  );

  always_comb begin
    wr_win_addr = req_addr[int'(wr_win_id)*ADDR_W +: ADDR_W];
    wr_win_data = req_wdata[int'(wr_win_id)*BD_DATA_W +: BD_DATA_W];
    rd_win_addr = req_addr[int'(rd_win_id)*ADDR_W +: ADDR_W];
  end

  // A read colliding with this cycle's write waits one cycle so it sees the new data.
  assign raw_hazard = wr_win_valid && rd_win_valid && (wr_win_addr == rd_win_addr);
  assign rd_hold    = reset || raw_hazard;

  assign req_ready  = wr_grant | rd_grant;
  assign ram_wrEn   = |wr_grant;
  assign ram_rdEn   = |rd_grant;
  assign ram_wrAddr = ram_wrEn ? wr_win_addr : '0;
  assign ram_wrData = ram_wrEn ? wr_win_data : '0;
  assign ram_rdAddr = ram_rdEn ? rd_win_addr : '0;

  logic [RD_LATENCY-1:0] tag_v;
  logic [ID_W-1:0]       tag_id [RD_LATENCY];
  logic                  err_v;
  logic [ID_W-1:0]       err_id;
`ifdef DMA_BD_ARB_ECC_LOG_EN
  logic [ADDR_W-1:0]     tag_addr [RD_LATENCY];
  logic [ADDR_W-1:0]     err_addr;
`endif

  // Tag pipeline: stage LAST lines up with ram_rdData, err_* one cycle later.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_v  <= '0;
      err_v  <= 1'b0;
      err_id <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_id[i] <= '0;
    end else begin
      tag_v[0]  <= ram_rdEn;
      tag_id[0] <= rd_win_id;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      err_v  <= tag_v[LAST];
      err_id <= tag_id[LAST];
    end
  end

`ifdef DMA_BD_ARB_ECC_LOG_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      err_addr <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_addr[i] <= '0;
    end else begin
      tag_addr[0] <= rd_win_addr;
      for (int i = 1; i < RD_LATENCY; i++) tag_addr[i] <= tag_addr[i-1];
      err_addr <= tag_addr[LAST];
    end
  end
`endif

  always_comb begin
    rsp_valid = '0;
    err_valid = '0;
    if (!reset && tag_v[LAST]) rsp_valid[tag_id[LAST]] = 1'b1;
    if (!reset && err_v)       err_valid[err_id]        = 1'b1;
  end

  assign rsp_data = (|rsp_valid) ? ram_rdData : '0;
  assign err_sb   = (|err_valid) & ram_sb;
  assign err_db   = (|err_valid) & ram_db;

`ifdef DMA_BD_ARB_ECC_LOG_EN
  logic first_err_seen;

  // Sticky log: first failing address wins; the single-bit count saturates.
  always_ff @(posedge clock) begin
    if (reset) begin
      first_err_seen <= 1'b0;
      first_err_addr <= '0;
      first_err_db   <= 1'b0;
      sb_count       <= '0;
    end else if (|err_valid) begin
      if ((err_sb || err_db) && !first_err_seen) begin
        first_err_seen <= 1'b1;
        first_err_addr <= err_addr;
        first_err_db   <= err_db;
      end
      if (err_sb && (sb_count != 16'hFFFF)) sb_count <= sb_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dma_bd_ram_arbiter.sv
// Directed bench for dma_bd_ram_arbiter with a behavioural BD RAM wrapper
// and a queue-based response/ECC scoreboard.
module tb_dma_bd_ram_arbiter;
  import dma_bd_pkg::*;

  localparam int N   = 3;
  localparam int AW  = 2;
  localparam int LAT = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid, req_we;
  logic [N*AW-1:0]   req_addr;
  logic [N*32-1:0]   req_wdata;
  logic [N-1:0]      req_ready, rsp_valid, err_valid;
  logic [31:0]       rsp_data;
  logic              err_sb, err_db;
  logic              ram_wrEn, ram_rdEn;
  logic [AW-1:0]     ram_wrAddr, ram_rdAddr;
  logic [31:0]       ram_wrData, ram_rdData;
  logic              ram_sb, ram_db;
`ifdef DMA_BD_ARB_ECC_LOG_EN
  logic [AW-1:0]     first_err_addr;
  logic              first_err_db;
  logic [15:0]       sb_count;
`endif

  dma_bd_ram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .RD_LATENCY(LAT)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .err_valid  (err_valid),
    .err_sb     (err_sb),
    .err_db     (err_db),
    .ram_wrEn   (ram_wrEn),
    .ram_wrAddr (ram_wrAddr),
    .ram_wrData (ram_wrData),
    .ram_rdEn   (ram_rdEn),
    .ram_rdAddr (ram_rdAddr),
    .ram_rdData (ram_rdData),
    .ram_sb     (ram_sb),
    .ram_db     (ram_db)
`ifdef DMA_BD_ARB_ECC_LOG_EN
    ,
    .first_err_addr (first_err_addr),
    .first_err_db   (first_err_db),
    .sb_count       (sb_count)
`endif
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Behavioural RAM wrapper: 2-cycle read data, ECC flags one cycle later.
  logic [31:0] mem [4];
  logic [31:0] rd_s1, rd_s2;
  logic        sb_s1, sb_s2, sb_s3, db_s1, db_s2, db_s3;
  logic        preload, inject_sb, inject_db;

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 4; i++) mem[i] <= 32'hA000_0000 + 32'(i);
    end else if (ram_wrEn) begin
      mem[ram_wrAddr] <= ram_wrData;
    end
    rd_s1 <= mem[ram_rdAddr];
    rd_s2 <= rd_s1;
    sb_s1 <= ram_rdEn & inject_sb;
    db_s1 <= ram_rdEn & inject_db;
    sb_s2 <= sb_s1;
    db_s2 <= db_s1;
    sb_s3 <= sb_s2;
    db_s3 <= db_s2;
  end

  assign ram_rdData = rd_s2;
  assign ram_sb     = sb_s3;
  assign ram_db     = db_s3;

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [N+31:0] exp_q[$];
  logic [N+1:0]  err_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_rd(input logic [N-1:0] oh, input logic [31:0] d,
                         input logic sb, input logic db);
    exp_q.push_back({oh, d});
    err_q.push_back({oh, sb, db});
  endtask

  always @(negedge clock) begin
    if (rsp_valid != '0) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 64'({rsp_valid, rsp_data}), 64'd0);
      else                   chk("rsp", 64'({rsp_valid, rsp_data}), 64'(exp_q.pop_front()));
    end
    if (err_valid != '0) begin
      if (err_q.size() == 0) chk("err_unexpected", 64'({err_valid, err_sb, err_db}), 64'd0);
      else                   chk("err", 64'({err_valid, err_sb, err_db}), 64'(err_q.pop_front()));
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [31:0] d);
    req_valid[i]          = 1'b1;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  task automatic clr_all();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_ram_en"}, 64'({ram_wrEn, ram_rdEn}), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_err_valid"}, 64'(err_valid), 64'd0);
  endtask

  initial begin
    clr_all();
    reset     = 1'b1;
    preload   = 1'b1;
    inject_sb = 1'b0;
    inject_db = 1'b0;
    tick();
    preload = 1'b0;
    @(negedge clock);
    chk_idle("por");
    chk("por_ram_bus", 64'({ram_wrAddr, ram_rdAddr, ram_wrData}), 64'd0);
    chk("por_rsp_data", 64'({rsp_data, err_sb, err_db}), 64'd0);
    tick();
    reset = 1'b0;

    // Reads in flight when reset hits are dropped
    set_req(REQ_FETCH, 1'b0, 2'd0, 32'd0);
    set_req(REQ_CFG,   1'b0, 2'd1, 32'd0);
    set_req(REQ_WB,    1'b0, 2'd2, 32'd0);
    @(negedge clock);
    chk("pre_rst_grant0", 64'(req_ready), 64'b001);
    tick();
    @(negedge clock);
    chk("pre_rst_grant1", 64'(req_ready), 64'b010);
    tick();
    reset = 1'b1;
    @(negedge clock);
    chk_idle("rst1");
    tick();
    @(negedge clock);
    chk_idle("rst2");
    tick();
    reset = 1'b0;

    // Round-robin from pointer 0, requests held continuously
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk("rr_grant", 64'(req_ready), 64'(3'b001 << (k % 3)));
      chk("rr_rden", 64'(ram_rdEn), 64'd1);
      push_rd(3'(3'b001 << (k % 3)), 32'hA000_0000 + 32'(k % 3), 1'b0, 1'b0);
      tick();
    end
    clr_all();
    repeat (4) tick();

    // Write then read through another requester
    set_req(REQ_FETCH, 1'b1, 2'd1, 32'hDEAD_BEEF);
    @(negedge clock);
    chk("wr_grant", 64'(req_ready), 64'b001);
    chk("wr_bus", 64'({ram_wrEn, ram_rdEn, ram_wrAddr, ram_wrData}),
        64'({1'b1, 1'b0, 2'd1, 32'hDEAD_BEEF}));
    tick();
    clr_all();
    set_req(REQ_CFG, 1'b0, 2'd1, 32'd0);
    @(negedge clock);
    chk("rd_grant", 64'(req_ready), 64'b010);
    chk("rd_bus", 64'({ram_rdEn, ram_rdAddr}), 64'({1'b1, 2'd1}));
    push_rd(3'b010, 32'hDEAD_BEEF, 1'b0, 1'b0);
    tick();
    clr_all();
    repeat (3) tick();

    // Read-after-write hazard on the same address
    set_req(REQ_FETCH, 1'b1, 2'd2, 32'h1234_5678);
    set_req(REQ_CFG,   1'b0, 2'd2, 32'd0);
    @(negedge clock);
    chk("raw_first", 64'({req_ready, ram_wrEn, ram_rdEn}), 64'({3'b001, 1'b1, 1'b0}));
    tick();
    req_valid[REQ_FETCH] = 1'b0;
    @(negedge clock);
    chk("raw_second", 64'({req_ready, ram_wrEn, ram_rdEn, ram_rdAddr}),
        64'({3'b010, 1'b0, 1'b1, 2'd2}));
    push_rd(3'b010, 32'h1234_5678, 1'b0, 1'b0);
    tick();
    clr_all();
    repeat (3) tick();

    // ECC flags: single-bit on requester 2, then double-bit on requester 0
    set_req(REQ_WB, 1'b0, 2'd3, 32'd0);
    inject_sb = 1'b1;
    @(negedge clock);
    chk("ecc_sb_grant", 64'(req_ready), 64'b100);
    push_rd(3'b100, 32'hA000_0003, 1'b1, 1'b0);
    tick();
    inject_sb = 1'b0;
    clr_all();
    set_req(REQ_FETCH, 1'b0, 2'd0, 32'd0);
    inject_db = 1'b1;
    @(negedge clock);
    chk("ecc_db_grant", 64'(req_ready), 64'b001);
    push_rd(3'b001, 32'hA000_0000, 1'b0, 1'b1);
    tick();
    inject_db = 1'b0;
    clr_all();
    repeat (4) tick();

    // Concurrent write and read on different addresses
    set_req(REQ_FETCH, 1'b1, 2'd0, 32'h0BAD_F00D);
    set_req(REQ_WB,    1'b0, 2'd3, 32'd0);
    @(negedge clock);
    chk("conc_grant", 64'({req_ready, ram_wrEn, ram_rdEn}), 64'({3'b101, 1'b1, 1'b1}));
    push_rd(3'b100, 32'hA000_0003, 1'b0, 1'b0);
    tick();
    clr_all();
    set_req(REQ_CFG, 1'b0, 2'd0, 32'd0);
    @(negedge clock);
    chk("conc_readback_grant", 64'(req_ready), 64'b010);
    push_rd(3'b010, 32'h0BAD_F00D, 1'b0, 1'b0);
    tick();
    clr_all();

    for (int w = 0; w < 20 && (exp_q.size() != 0 || err_q.size() != 0); w++) tick();
    tick();
    chk("drain_rsp", 64'(exp_q.size()), 64'd0);
    chk("drain_err", 64'(err_q.size()), 64'd0);

`ifdef DMA_BD_ARB_ECC_LOG_EN
    chk("log_sb_count", 64'(sb_count), 64'd1);
    chk("log_first_addr", 64'(first_err_addr), 64'd3);
    chk("log_first_db", 64'(first_err_db), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
